// File: rtl/demux_lane_sched_pkg.sv
// Shared types and helpers for the demux lane scheduler and its picker.
package demux_sched_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_BURST = 8;
  localparam int ONEHOT_MAX    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Callers truncate the result to their own lane count.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx);
    onehot = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/demux_lane_sched_if.sv
// Serial source handshake plus the demuxN drive and per-lane status lines.
interface demux_lane_sched_if
  import demux_sched_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = $clog2(N)
);
  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic [N-1:0]     lane_ready;
  logic             dmx_en;
  logic [SEL_W-1:0] dmx_sel;
  logic             dmx_xin;
  logic [N-1:0]     lane_valid;

  // master: the scheduler; slave: the source/lane side.
  modport master (
    input  in_valid, in_data, lane_ready,
    output in_ready, dmx_en, dmx_sel, dmx_xin, lane_valid
  );

  modport slave (
    output in_valid, in_data, lane_ready,
    input  in_ready, dmx_en, dmx_sel, dmx_xin, lane_valid
  );
endinterface

// File: rtl/demux_lane_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit searching cyclically from ptr+1.
module rr_pick
  import demux_sched_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int w_idx;

  assign gnt_any = |req;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    w_idx   = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (req[SEL_W'(w_idx)]) begin
        gnt_idx = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/demux_lane_sched.sv
// Round-robin burst scheduler feeding a shared N-way bit demux from one serial stream.
module demux_lane_sched
  import demux_sched_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int BURST = DEFAULT_BURST,
  parameter int SEL_W = $clog2(N),
  parameter int CNT_W = $clog2(BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        cfg_mask,
  demux_lane_sched_if.master  bus,
  output logic                busy,
  output logic                burst_done,
  output logic                burst_abort
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_cur;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     w_elig;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic             w_cur_en;
  logic             w_cur_rdy;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_last;
  logic             w_abort;

  logic             r_dmx_en;
  logic [SEL_W-1:0] r_dmx_sel;
  logic             r_dmx_xin;
  logic [N-1:0]     r_lane_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_abort;

  logic             w_dmx_en_next;
  logic [SEL_W-1:0] w_dmx_sel_next;
  logic             w_dmx_xin_next;
  logic [N-1:0]     w_lane_valid_next;
  logic             w_done_next;
  logic             w_abort_next;

  assign w_elig     = cfg_mask & bus.lane_ready;
  assign w_cur_en   = cfg_mask[r_cur];
  assign w_cur_rdy  = bus.lane_ready[r_cur];
  assign w_in_ready = (r_state == XFER) && w_cur_rdy && w_cur_en;
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(BURST - 1));
  assign w_abort    = (r_state == XFER) && !w_cur_en;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (w_elig),
    .ptr     (r_ptr),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_gnt_any) w_state_next = XFER;
      XFER: if (w_abort || (w_xfer && w_last)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_dmx_en_next     = w_xfer;
    w_dmx_sel_next    = w_xfer ? r_cur : r_dmx_sel;
    w_dmx_xin_next    = w_xfer && bus.in_data;
    w_lane_valid_next = w_xfer ? N'(onehot(int'(r_cur))) : '0;
    w_done_next       = w_xfer && w_last;
    w_abort_next      = w_abort;
  end

  // Pointer only advances when a burst ends, so the grant order rotates per burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_cur <= '0;
      r_ptr <= SEL_W'(N - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_cur <= w_gnt_idx;
            r_cnt <= '0;
          end
        end
        XFER: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_abort || (w_xfer && w_last)) begin
            r_ptr <= r_cur;
          end
        end
        default: ;
      endcase
    end
  end

  // busy lags the state by one cycle to line up with the delayed lane strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmx_en     <= 1'b0;
      r_dmx_sel    <= '0;
      r_dmx_xin    <= 1'b0;
      r_lane_valid <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_dmx_en     <= w_dmx_en_next;
      r_dmx_sel    <= w_dmx_sel_next;
      r_dmx_xin    <= w_dmx_xin_next;
      r_lane_valid <= w_lane_valid_next;
      r_busy       <= (r_state == XFER);
      r_done       <= w_done_next;
      r_abort      <= w_abort_next;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.dmx_en     = r_dmx_en;
  assign bus.dmx_sel    = r_dmx_sel;
  assign bus.dmx_xin    = r_dmx_xin;
  assign bus.lane_valid = r_lane_valid;
  assign busy           = r_busy;
  assign burst_done     = r_done;
  assign burst_abort    = r_abort;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Directed bench for demux_lane_sched: rotation, masking, stall, abort, reset and single-lane reuse.
module tb_demux_lane_sched;
  import demux_sched_pkg::*;

  localparam int N     = 4;
  localparam int BURST = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] cfg_mask;
  logic         busy;
  logic         burst_done;
  logic         burst_abort;
  logic         started = 1'b0;

  int checks = 0;
  int errors = 0;

  demux_lane_sched_if #(.N(N)) bus ();

  demux_lane_sched #(
    .N     (N),
    .BURST (BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_mask    (cfg_mask),
    .bus         (bus),
    .busy        (busy),
    .burst_done  (burst_done),
    .burst_abort (burst_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the pick cycle; leaves in the cycle after the last bit offered.
  task automatic burst(input int lane, input int nbits, input int stall_at, input int stall_len);
    logic         d;
    logic [N-1:0] lv;
    lv = N'(1) << lane;
    #1;
    chk("pick_in_ready", bus.in_ready, 0);
    tick();
    chk("gap_lane_valid", bus.lane_valid, 0);
    chk("gap_dmx_en", bus.dmx_en, 0);
    chk("gap_busy", busy, 0);
    chk("gap_abort", burst_abort, 0);
    chk("gap_done", burst_done, 0);
    for (int k = 0; k < nbits; k++) begin
      if (k == stall_at) begin
        bus.lane_ready[lane] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_in_ready", bus.in_ready, 0);
          tick();
          chk("stall_lane_valid", bus.lane_valid, 0);
          chk("stall_sel_hold", bus.dmx_sel, lane);
          chk("stall_xin", bus.dmx_xin, 0);
        end
        bus.lane_ready[lane] = 1'b1;
      end
      d = 1'($urandom_range(0, 1));
      bus.in_data = d;
      #1;
      chk("xfer_in_ready", bus.in_ready, 1);
      tick();
      chk("xfer_lane_valid", bus.lane_valid, lv);
      chk("xfer_dmx_en", bus.dmx_en, 1);
      chk("xfer_dmx_sel", bus.dmx_sel, lane);
      chk("xfer_dmx_xin", bus.dmx_xin, d);
      chk("xfer_done", burst_done, (k == BURST - 1) ? 1 : 0);
      chk("xfer_abort", burst_abort, 0);
      chk("xfer_busy", busy, 1);
    end
    $display("burst lane=%0d bits=%0d stall_at=%0d stall_len=%0d checks=%0d errors=%0d",
             lane, nbits, stall_at, stall_len, checks, errors);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lane_valid"}, bus.lane_valid, 0);
    chk({tag, "_dmx_en"}, bus.dmx_en, 0);
    chk({tag, "_dmx_sel"}, bus.dmx_sel, 0);
    chk({tag, "_dmx_xin"}, bus.dmx_xin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, burst_done, 0);
    chk({tag, "_abort"}, burst_abort, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("inv_onehot0", $onehot0(bus.lane_valid), 1);
      if (|bus.lane_valid) begin
        chk("inv_en", bus.dmx_en, 1);
        chk("inv_sel", bus.lane_valid, N'(1) << bus.dmx_sel);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    cfg_mask       = 4'b1111;
    bus.lane_ready = 4'b1111;
    bus.in_valid   = 1'b1;
    bus.in_data    = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    $display("reset checks=%0d errors=%0d", checks, errors);
    rst     = 1'b0;
    started = 1'b1;

    burst(0, BURST, -1, 0);
    burst(1, BURST, -1, 0);
    burst(2, BURST, -1, 0);
    burst(3, BURST, -1, 0);
    burst(0, BURST, -1, 0);

    cfg_mask = 4'b1010;
    burst(1, BURST, -1, 0);
    burst(3, BURST, -1, 0);
    burst(1, BURST, -1, 0);
    burst(3, BURST, -1, 0);

    cfg_mask = 4'b1111;
    burst(0, BURST, 3, 5);

    burst(1, 5, -1, 0);
    cfg_mask[1] = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    tick();
    chk("abort_pulse", burst_abort, 1);
    chk("abort_no_done", burst_done, 0);
    chk("abort_lane_valid", bus.lane_valid, 0);
    chk("abort_busy", busy, 1);
    $display("abort lane=1 checks=%0d errors=%0d", checks, errors);
    cfg_mask = 4'b1111;

    burst(2, 5, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    $display("mid-burst reset checks=%0d errors=%0d", checks, errors);
    burst(0, BURST, -1, 0);

    cfg_mask = 4'b0100;
    burst(2, BURST, -1, 0);
    burst(2, BURST, -1, 0);
    burst(2, BURST, -1, 0);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
